// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - read-side adapter turning a latency-1 FIFO into a valid/ready stream
//
// Purpose:
//   Sits directly after a non-lookahead sync_fifo. Issues fifo_rd_en from
//   registered state only, captures each word one cycle after its read,
//   and presents it from a 3-entry holding buffer on a valid/ready stream.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-low reset
//   fifo_empty  in   FIFO empty flag
//   fifo_data   in   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  out  FIFO read enable
//   flush       in   synchronous discard of buffered and in-flight words
//   out_data    out  stream data (buffer head)
//   out_valid   out  stream valid
//   out_ready   in   stream ready from consumer
//   rd_count    out  number of accepted stream handshakes (wrapping)

module fifo_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_WIDTH-1:0]  rd_count
);

    localparam int DEPTH = 3;

    // Holding buffer state
    logic [DATA_WIDTH-1:0] r_buf [DEPTH];
    logic [1:0]            r_wr_ptr;
    logic [1:0]            r_rd_ptr;
    logic [1:0]            r_occ;
    logic                  r_inflight;
    logic [CNT_WIDTH-1:0]  r_rd_count;

    logic [2:0]            w_level;
    logic                  w_room;
    logic                  w_rd_en;
    logic                  w_push;
    logic                  w_pop;
    logic [1:0]            w_occ_next;
    logic [1:0]            w_wr_ptr_next;
    logic [1:0]            w_rd_ptr_next;

    // Circular pointer advance over three entries: 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        ptr_inc = (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Words already held plus the one that may arrive next edge. Issuing
    // only while this is at most 2 guarantees every in-flight word has a
    // slot, so the read path never needs to look at out_ready.
    assign w_level = {1'b0, r_occ} + {2'b00, r_inflight};
    assign w_room  = (w_level <= 3'd2);
    assign w_rd_en = rst & ~flush & ~fifo_empty & w_room;

    assign w_push = r_inflight;
    assign w_pop  = out_valid & out_ready;

    assign w_wr_ptr_next = w_push ? ptr_inc(r_wr_ptr) : r_wr_ptr;
    assign w_rd_ptr_next = w_pop  ? ptr_inc(r_rd_ptr) : r_rd_ptr;

    always_comb begin
        w_occ_next = r_occ;
        case ({w_push, w_pop})
            2'b10:   w_occ_next = r_occ + 2'd1;
            2'b01:   w_occ_next = r_occ - 2'd1;
            default: w_occ_next = r_occ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr   <= 2'd0;
            r_rd_ptr   <= 2'd0;
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
            r_rd_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            // A handshake in a flush cycle was already seen by the consumer,
            // so it is counted even though the buffer is being discarded.
            if (w_pop) begin
                r_rd_count <= r_rd_count + 1'b1;
            end

            if (flush) begin
                // Word on fifo_data this cycle is dropped by not capturing it.
                r_wr_ptr   <= 2'd0;
                r_rd_ptr   <= 2'd0;
                r_occ      <= 2'd0;
                r_inflight <= 1'b0;
            end else begin
                r_inflight <= w_rd_en;
                r_wr_ptr   <= w_wr_ptr_next;
                r_rd_ptr   <= w_rd_ptr_next;
                r_occ      <= w_occ_next;
                if (w_push) begin
                    r_buf[r_wr_ptr] <= fifo_data;
                end
            end
        end
    end

    // No bypass: data is always presented from the buffer head.
    assign fifo_rd_en = w_rd_en;
    assign out_valid  = (r_occ != 2'd0);
    assign out_data   = r_buf[r_rd_ptr];
    assign rd_count   = r_rd_count;

endmodule
